// File: rtl/rv32_ctrl_pkg.sv
// Shared RV32 decode constants: opcodes, funct7 values, ALU operation codes and the control bundle.
// MUL..REMU codes are contiguous in funct3 order so the M-extension decode can offset from ALU_MUL.
package rv32_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        logic    branch;
        logic    jump;
        logic    illegal;
        alu_op_e alu;
    } ctrl_t;

    // alt selects SUB (R-type only) / SRA; callers pass 0 where SUB must not apply.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt_add,
                                                input logic alt_shift);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt_add ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt_shift ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational immediate generator: selects the I/S/B/U/J format from the opcode and sign-extends to XLEN.
module rv32_imm_gen #(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);
    import rv32_ctrl_pkg::*;

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {instr[31:12], 12'b0};
            OP_JAL:
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rv32i_decode_stage.sv
// Registered RV32 ID stage: decode to a control bundle held in the ID/EX register behind valid/ready.
// Define RV32_MULDIV_EN to decode the M extension and stall intake for MULDIV_LAT cycles per op.
module rv32i_decode_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ALU_CTRL_W = 5,
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [XLEN-1:0]       in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_mem_to_reg,
    output logic                  out_alu_src,
    output logic                  out_branch,
    output logic                  out_jump,
    output logic [ALU_CTRL_W-1:0] out_alu_ctrl,
    output logic [2:0]            out_funct3,
    output logic [4:0]            out_rd,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [XLEN-1:0]       out_imm,
    output logic [XLEN-1:0]       out_pc,
    output logic                  out_illegal,
    output logic                  hazard_stall
);
    import rv32_ctrl_pkg::*;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    ctrl_t           dec;
    logic [XLEN-1:0] imm;
    logic            reads_rs2;
    logic            hazard;
    logic            busy_free;
    logic            accept;
    logic            drain;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];

    rv32_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr),
        .imm   (imm)
    );

    always_comb begin
        dec     = '0;
        dec.alu = ALU_ADD;
        case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                    dec.reg_write = 1'b1;
                    dec.alu       = alu_from_funct3(funct3, funct7[5], funct7[5]);
                end
`ifdef RV32_MULDIV_EN
                else if (funct7 == F7_MULDIV) begin
                    dec.reg_write = 1'b1;
                    dec.alu       = alu_op_e'(5'(ALU_MUL) + 5'(funct3));
                end
`endif
                else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu       = alu_from_funct3(funct3, 1'b0, in_instr[30]);
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = 1'b1;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch = 1'b1;
                dec.alu    = ALU_SUB;
            end
            OP_JAL, OP_JALR: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                dec.alu_src   = 1'b1;
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu       = ALU_PASSB;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign reads_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

    assign hazard = out_valid && out_mem_read && (out_rd != 5'd0) && in_valid &&
                    ((rs1 == out_rd) || (reads_rs2 && (rs2 == out_rd)));

    assign in_ready     = !flush && !hazard && busy_free && (!out_valid || out_ready);
    assign hazard_stall = hazard && out_ready && !flush;
    assign accept       = in_valid && in_ready;
    // Register empties (bubble or drain) when EX took the bundle and nothing new is accepted.
    assign drain        = !accept && (flush || out_ready || !out_valid);

`ifdef RV32_MULDIV_EN
    localparam int unsigned BUSY_W = $clog2(MULDIV_LAT + 1);
    logic [BUSY_W-1:0] busy_cnt;
    logic              is_muldiv;

    assign is_muldiv = (opcode == OP_R) && (funct7 == F7_MULDIV);
    assign busy_free = (busy_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= '0;
        end else if (flush) begin
            busy_cnt <= '0;
        end else if (accept && is_muldiv) begin
            busy_cnt <= BUSY_W'(MULDIV_LAT - 1);
        end else if (busy_cnt != '0) begin
            busy_cnt <= busy_cnt - 1'b1;
        end
    end
`else
    assign busy_free = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_alu_src    <= 1'b0;
            out_branch     <= 1'b0;
            out_jump       <= 1'b0;
            out_illegal    <= 1'b0;
            out_alu_ctrl   <= '0;
            out_funct3     <= '0;
            out_rd         <= '0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            out_imm        <= '0;
            out_pc         <= '0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_reg_write  <= dec.reg_write;
            out_mem_read   <= dec.mem_read;
            out_mem_write  <= dec.mem_write;
            out_mem_to_reg <= dec.mem_to_reg;
            out_alu_src    <= dec.alu_src;
            out_branch     <= dec.branch;
            out_jump       <= dec.jump;
            out_illegal    <= dec.illegal;
            out_alu_ctrl   <= ALU_CTRL_W'(dec.alu);
            out_funct3     <= funct3;
            out_rd         <= in_instr[11:7];
            out_rs1        <= rs1;
            out_rs2        <= rs2;
            out_imm        <= imm;
            out_pc         <= in_pc;
        end else if (drain) begin
            out_valid      <= 1'b0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_branch     <= 1'b0;
            out_jump       <= 1'b0;
            out_illegal    <= 1'b0;
        end
    end

endmodule
